// File: rtl/fifo_tx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_tx_seq_pkg
// Brief   : State encoding and default widths shared by the FIFO-to-TX sequencer
// Revision: 1.0
// ============================================================================
package fifo_tx_seq_pkg;

  localparam int c_DATA_WIDTH = 8;
  localparam int c_CNT_WIDTH  = 16;

  typedef logic [2:0] state_t;

  localparam state_t c_ST_IDLE      = 3'd0;
  localparam state_t c_ST_POP       = 3'd1;
  localparam state_t c_ST_START     = 3'd2;
  localparam state_t c_ST_WAIT_BUSY = 3'd3;
  localparam state_t c_ST_WAIT_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module  : seq_timeout_cnt
// Brief   : Clearable cycle counter flagging TIMEOUT_CYCLES-1 counted cycles
// Revision: 1.0
// ============================================================================
module seq_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [c_CW-1:0] r_cnt;

  // Holds at the terminal value so the count can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count_en && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_tx_sequencer
// Brief   : Pops one FIFO byte at a time into the UART TX via start/busy.
//           Define FIFO_TX_SEQ_TIMEOUT_EN to add the tx_busy rise timeout.
// Revision: 1.0
// ============================================================================
module fifo_tx_sequencer
  import fifo_tx_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH,
  parameter int CNT_WIDTH      = c_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_pop,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  active,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic                  err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_fifo_pop;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_active;
  logic [CNT_WIDTH-1:0]  r_sent_cnt;
  logic                  w_start_ok;
  logic                  w_timeout;

  assign w_start_ok = enable && !fifo_empty && !tx_busy;

`ifdef FIFO_TX_SEQ_TIMEOUT_EN
  logic w_expired;
  logic r_err;

  // START is the only way into WAIT_BUSY, so clearing there restarts the count on entry.
  seq_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == c_ST_START),
    .count_en((r_state == c_ST_WAIT_BUSY) && !tx_busy),
    .expired (w_expired)
  );

  assign w_timeout = (r_state == c_ST_WAIT_BUSY) && !tx_busy && w_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign err = r_err;
`else
  wire w_unused_timeout = (TIMEOUT_CYCLES == 0);

  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:      if (w_start_ok) w_state_nxt = c_ST_POP;
      c_ST_POP:       w_state_nxt = c_ST_START;
      c_ST_START:     w_state_nxt = c_ST_WAIT_BUSY;
      c_ST_WAIT_BUSY: begin
        if (tx_busy)        w_state_nxt = c_ST_WAIT_DONE;
        else if (w_timeout) w_state_nxt = c_ST_IDLE;
      end
      c_ST_WAIT_DONE: if (!tx_busy) w_state_nxt = c_ST_IDLE;
      default:        w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Strobes and active are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_fifo_pop <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_active   <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fifo_pop <= (w_state_nxt == c_ST_POP);
      r_tx_start <= (w_state_nxt == c_ST_START);
      r_active   <= (w_state_nxt != c_ST_IDLE);
      if ((r_state == c_ST_IDLE) && w_start_ok) begin
        r_tx_data <= fifo_rdata;
      end
      if ((r_state == c_ST_WAIT_DONE) && !tx_busy) begin
        r_sent_cnt <= r_sent_cnt + 1'b1;
      end
    end
  end

  assign fifo_pop = r_fifo_pop;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign active   = r_active;
  assign sent_cnt = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_tx_sequencer
// Brief   : Scoreboard bench with FIFO and UART TX behavioural models
// Revision: 1.0
// ============================================================================
module tb_fifo_tx_sequencer;

  localparam int c_DW = 8;
  localparam int c_CW = 4;
  localparam int c_TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [c_DW-1:0] fifo_rdata = '0;
  logic            fifo_pop;
  logic            tx_busy = 1'b0;
  logic            tx_start;
  logic [c_DW-1:0] tx_data;
  logic            active;
  logic [c_CW-1:0] sent_cnt;
  logic            err;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int n_start = 0;
  int busy_len = 10;
  int busy_cnt = 0;
  bit tx_model_en = 1'b1;
  int exp_sent = 0;

  logic [c_DW-1:0] fifo_q[$];
  logic [c_DW-1:0] exp_q[$];
  logic            pop_now;
  logic            st_now;
  logic [c_DW-1:0] last_tx = '0;

  fifo_tx_sequencer #(
    .DATA_WIDTH    (c_DW),
    .CNT_WIDTH     (c_CW),
    .TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_pop  (fifo_pop),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .active    (active),
    .sent_cnt  (sent_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // FIFO model: pops on the edge that ends a fifo_pop cycle.
  always @(posedge clk) begin
    pop_now = fifo_pop;
    #1;
    if (pop_now && !rst && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // UART TX model: busy rises one cycle after tx_start, lasts busy_len cycles.
  always @(posedge clk) begin
    st_now = tx_start;
    #1;
    if (rst) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (st_now && tx_model_en) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  // Scoreboard and protocol monitor
  always @(negedge clk) begin
    if (rst) begin
      last_tx = '0;
    end else begin
      if (fifo_pop) n_pop++;
      if (tx_start) begin
        n_start++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: tx_start with data %h, no byte expected", tx_data);
        end else begin
          logic [c_DW-1:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: tx_data=%h expected=%h", tx_data, e);
          end
        end
        if (tx_busy) begin
          n_cmp++; n_fail++;
          $display("FAIL start_while_busy: tx_start=1 tx_busy=%b expected tx_busy=0", tx_busy);
        end
      end
      if (fifo_pop && fifo_empty) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_while_empty: fifo_pop=1 fifo_empty=%b expected 0", fifo_empty);
      end
      if (!fifo_pop && tx_data !== last_tx) begin
        n_cmp++; n_fail++;
        $display("FAIL tx_data_stable: tx_data=%h expected held %h", tx_data, last_tx);
      end
      last_tx = tx_data;
    end
  end

  task automatic push_byte(input logic [c_DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
    fifo_rdata = fifo_q[0];
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!active && fifo_q.size() == 0 && !tx_busy) break;
    end
    if (i >= budget) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    push_byte(8'h3C);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({fifo_pop, tx_start, active, sent_cnt, err, tx_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: pop=%b start=%b active=%b cnt=%h err=%b data=%h expected all 0",
                 fifo_pop, tx_start, active, sent_cnt, err, tx_data);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_pop !== 1'b1 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_pop: pop=%b start=%b expected pop=1 start=0", fifo_pop, tx_start);
    end
    wait_idle(100, "reset");
    exp_sent = (exp_sent + 1) % 16;
    n_cmp++;
    if (sent_cnt !== c_CW'(exp_sent)) begin
      n_fail++;
      $display("FAIL reset_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    push_byte(8'hA5);
    @(negedge clk);
    n_cmp++;
    if (fifo_pop !== 1'b1 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop_latency: pop=%b start=%b expected pop=1 start=0", fifo_pop, tx_start);
    end
    @(negedge clk);
    n_cmp++;
    if (fifo_pop !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_start_latency: pop=%b start=%b data=%h expected pop=0 start=1 data=a5",
               fifo_pop, tx_start, tx_data);
    end
    wait_idle(100, "single");
    exp_sent = (exp_sent + 1) % 16;
    n_cmp++;
    if (sent_cnt !== c_CW'(exp_sent) || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_done: cnt=%0d data=%h expected cnt=%0d data=a5", sent_cnt, tx_data, exp_sent);
    end
  endtask

  task automatic test_burst();
    enable = 1'b0;
    @(negedge clk);
    n_pop = 0;
    n_start = 0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    @(negedge clk);
    enable = 1'b1;
    wait_idle(300, "burst");
    exp_sent = (exp_sent + 4) % 16;
    chk("burst_pops", n_pop, 4);
    chk("burst_starts", n_start, 4);
    chk("burst_sent_cnt", sent_cnt, exp_sent);
    chk("burst_sb_drained", exp_q.size(), 0);
  endtask

  task automatic test_enable_mid();
    int i;
    @(negedge clk);
    n_pop = 0;
    push_byte(8'h5C);
    push_byte(8'hC5);
    for (i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
    if (i >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL en_busy_timeout: tx_busy=%b expected 1 within 50 cycles", tx_busy);
    end
    enable = 1'b0;
    for (i = 0; i < 50 && active; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    exp_sent = (exp_sent + 1) % 16;
    chk("en_low_pops", n_pop, 1);
    chk("en_low_sent_cnt", sent_cnt, exp_sent);
    chk("en_low_active", active, 0);
    chk("en_low_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    wait_idle(100, "en_resume");
    exp_sent = (exp_sent + 1) % 16;
    chk("en_resume_pops", n_pop, 2);
    chk("en_resume_sent_cnt", sent_cnt, exp_sent);
  endtask

  task automatic test_async_reset();
    int i;
    @(negedge clk);
    push_byte(8'h96);
    for (i = 0; i < 50 && !tx_start; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({fifo_pop, tx_start, active, sent_cnt, err, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL async_rst_clear: pop=%b start=%b active=%b cnt=%h err=%b data=%h expected all 0",
               fifo_pop, tx_start, active, sent_cnt, err, tx_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_sent = 0;
    n_start = 0;
    repeat (10) @(negedge clk);
    chk("async_no_extra_start", n_start, 0);
    chk("async_idle", active, 0);
    push_byte(8'h69);
    wait_idle(100, "async_restart");
    exp_sent = (exp_sent + 1) % 16;
    chk("async_restart_starts", n_start, 1);
    chk("async_restart_cnt", sent_cnt, exp_sent);
  endtask

  task automatic test_wrap();
    busy_len = 2;
    @(negedge clk);
    for (int k = 0; k < 15; k++) push_byte(8'(8'h80 + k));
    wait_idle(600, "wrap");
    exp_sent = (exp_sent + 15) % 16;
    chk("wrap_to_zero", sent_cnt, exp_sent);
    push_byte(8'hEE);
    wait_idle(100, "wrap_next");
    exp_sent = (exp_sent + 1) % 16;
    chk("wrap_next", sent_cnt, exp_sent);
  endtask

  task automatic test_timeout();
    int i;
    tx_model_en = 1'b0;
    @(negedge clk);
    push_byte(8'h7E);
    for (i = 0; i < 50 && !tx_start; i++) @(negedge clk);
`ifdef FIFO_TX_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if (err !== (k == 9)) begin
        n_fail++;
        $display("FAIL timeout_err_c%0d: err=%b expected %b", k, err, (k == 9));
      end
    end
    chk("timeout_idle", active, 0);
    chk("timeout_cnt_kept", sent_cnt, exp_sent);
    @(negedge clk);
    chk("timeout_err_single", err, 0);
`else
    begin
      bit seen_err = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (err !== 1'b0) seen_err = 1'b1;
      end
      chk("no_timeout_err", seen_err, 0);
    end
    chk("no_timeout_active", active, 1);
    chk("no_timeout_cnt", sent_cnt, exp_sent);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_enable_mid();
    test_async_reset();
    test_wrap();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/fifo_tx_sequencer.md
Name: fifo_tx_sequencer

Overview:
- Drains the RX-side FIFO into the UART transmitter, one byte at a time, under a start/busy handshake.
- Sits between the FIFO control/memory pair (empty flag, asynchronous read data at rptr, pop strobe) and the UART TX core (tx_start pulse, tx_busy level).
- Guarantees exactly one pop and exactly one tx_start per byte, and never issues a start while TX is busy.

Parameters:
- DATA_WIDTH, 8, width of FIFO read data and TX data.
- CNT_WIDTH, 16, width of the sent-byte counter.
- TIMEOUT_CYCLES, 1024, clock cycles to wait for tx_busy to rise after tx_start. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  level; permits starting a new byte.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  DATA_WIDTH  FIFO data at the current rptr, valid combinationally.
- fifo_pop  output  1  one-cycle pop strobe to the FIFO.
- tx_busy  input  1  UART TX busy level.
- tx_start  output  1  one-cycle start strobe to the UART TX.
- tx_data  output  DATA_WIDTH  byte presented to the UART TX; held stable until the next pop.
- active  output  1  high whenever the state is not IDLE.
- sent_cnt  output  CNT_WIDTH  count of completed bytes; wraps modulo 2^CNT_WIDTH.
- err  output  1  one-cycle timeout pulse. Tied 0 without the optional feature.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk, with asynchronous active-high reset, rst. While rst is high:
  - state = IDLE
  - fifo_pop = 0, tx_start = 0, tx_data = 0, active = 0, sent_cnt = 0, err = 0, timeout counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, POP, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Leaves to POP when enable=1, fifo_empty=0 and tx_busy=0, all sampled on the same edge.
  - On that edge: tx_data <= fifo_rdata, and fifo_pop <= 1.
- POP: fifo_pop is high for exactly this one cycle. Next state is START.
- START: fifo_pop <= 0, tx_start <= 1 for one cycle. Next state is WAIT_BUSY.
- WAIT_BUSY: tx_start <= 0; go to WAIT_DONE on tx_busy=1.
- WAIT_DONE: on tx_busy=0, go to IDLE and increment sent_cnt on the same edge.
- Latency:
  - Qualifying IDLE edge to fifo_pop high: 1 cycle.
  - Qualifying IDLE edge to tx_start high: 2 cycles.
  - Minimum gap from tx_busy falling to the next fifo_pop: 2 cycles (WAIT_DONE->IDLE, IDLE->POP).
- enable deasserted mid-transfer: the current byte completes normally; no new pop occurs until enable=1.
- fifo_empty is ignored outside IDLE.
- A push arriving while empty makes fifo_empty=0 one cycle after the push. The sequencer starts on the next qualifying IDLE edge.
- tx_busy already high in IDLE: the sequencer waits and pops nothing.
- sent_cnt wraps: all-ones + 1 = 0, with no flag.
- Asynchronous reset in any state returns everything to reset values immediately. A byte already popped but not sent is lost; this is accepted.

Optional Feature:
- Macro: FIFO_TX_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_BUSY, a counter counts cycles with tx_busy=0.
  - When it reaches TIMEOUT_CYCLES-1, the next state is IDLE, err pulses for 1 cycle and sent_cnt is not incremented.
  - The counter clears on entry to WAIT_BUSY.
- Not defined:
  - No counter logic is built and err is tied 0.
  - WAIT_BUSY waits indefinitely.

Decomposition:
- Shared package fifo_tx_seq_pkg holds:
  - the state encoding localparams (IDLE=0, POP=1, START=2, WAIT_BUSY=3, WAIT_DONE=4) in a 3-bit state type;
  - the default DATA_WIDTH and CNT_WIDTH constants.
- One sub-module is natural: seq_timeout_cnt (clear, count-enable, expired output). It is instantiated only under FIFO_TX_SEQ_TIMEOUT_EN.
- Everything else stays in one FSM plus datapath registers.

Test Plan:
- Reset: hold rst=1 for 3 cycles with fifo_empty=0 and enable=1 -> fifo_pop, tx_start, active, sent_cnt and err all 0; first fifo_pop 1 cycle after rst release.
- Single byte: fifo_rdata=0xA5, fifo_empty=0, tx_busy model rises 1 cycle after start and holds 10 cycles -> fifo_pop 1 cycle, tx_start 1 cycle later, tx_data=0xA5 stable until IDLE, sent_cnt=1.
- Burst: FIFO model with DEPTH=4, full with 0x11, 0x22, 0x33, 0x44 -> exactly 4 pops and 4 starts, tx_data in order, sent_cnt=4, no pop while fifo_empty=1, no start while tx_busy=1.
- enable low mid-byte: deassert enable during WAIT_DONE with 2 bytes queued -> current byte completes (sent_cnt+1), no further pop until enable=1 again, then the remaining byte is sent.
- Asynchronous reset mid-transfer: assert rst during WAIT_BUSY -> outputs clear within the same cycle, no extra tx_start, and after release the sequencer restarts from IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=8): tx_busy held 0 after start -> err pulses once 8 cycles after entering WAIT_BUSY, state returns to IDLE, sent_cnt unchanged. Without the macro: err stays 0 and active stays 1.
